// File: rtl/issue_scoreboard_pkg.sv
// Shared types and lane-slicing helpers for the in-order issue controller.
package hazard_pkg;

  localparam int BUS_MAX   = 64;
  localparam int FIELD_MAX = 8;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PART = 1'b1
  } issueState_e;

  function automatic int laneIdxW(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Extract lane `lane` of a packed per-lane bus whose fields are `width` bits wide.
  function automatic logic [FIELD_MAX-1:0] laneField(input logic [BUS_MAX-1:0] bus,
                                                     input int lane, input int width);
    logic [BUS_MAX-1:0]   shifted;
    logic [FIELD_MAX-1:0] mask;
    shifted = bus >> (lane * width);
    mask    = (FIELD_MAX'(1) << width) - FIELD_MAX'(1);
    return shifted[FIELD_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/issue_scoreboard_reg.sv
// Per-register latency countdown with issue loads and redirect release of young writers.
module reg_scoreboard import hazard_pkg::*; #(
  parameter  int LANES = 2,
  parameter  int NREG  = 32,
  parameter  int REGW  = 5,
  parameter  int LAT_W = 3,
  localparam int LIW   = laneIdxW(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES-1:0]       ldEn,
  input  logic [LANES*REGW-1:0]  ldReg,
  input  logic [LANES*LAT_W-1:0] ldLat,
  input  logic                   relValid,
  input  logic [LIW-1:0]         relLane,
  output logic [NREG-1:0]        busy
);

  logic [LAT_W-1:0] cnt       [NREG];
  logic [LIW-1:0]   owner     [NREG];
  logic [NREG-1:0]  young;
  logic [NREG-1:0]  loadHit;
  logic [LAT_W-1:0] loadLat   [NREG];
  logic [LIW-1:0]   loadOwner [NREG];

  // Route each writing lane to its destination entry; x0 is never tracked.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      loadHit[r]   = 1'b0;
      loadLat[r]   = '0;
      loadOwner[r] = '0;
      for (int l = 0; l < LANES; l++) begin
        if ((r != 0) && ldEn[l] &&
            (REGW'(laneField(BUS_MAX'(ldReg), l, REGW)) == REGW'(r))) begin
          loadHit[r]   = 1'b1;
          loadLat[r]   = LAT_W'(laneField(BUS_MAX'(ldLat), l, LAT_W));
          loadOwner[r] = LIW'(l);
        end else begin
          loadHit[r]   = loadHit[r];
        end
      end
    end
  end

  // Countdown update: a load wins, then redirect release, then plain decrement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      young <= '0;
      for (int r = 0; r < NREG; r++) begin
        cnt[r]   <= '0;
        owner[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (loadHit[r]) begin
          cnt[r]   <= loadLat[r];
          owner[r] <= loadOwner[r];
          young[r] <= 1'b1;
        end else begin
          young[r] <= 1'b0;
          if (relValid && young[r] && (owner[r] > relLane)) begin
            cnt[r] <= '0;
          end else if (cnt[r] != '0) begin
            cnt[r] <= cnt[r] - LAT_W'(1);
          end
        end
      end
    end
  end

  // A register is busy while its result is still in flight.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy[r] = (cnt[r] != '0);
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// N-lane in-order issue controller: picks the issuable prefix of the decode bundle,
// splits dependent bundles across cycles and squashes younger work on redirect.
module issue_scoreboard import hazard_pkg::*; #(
  parameter  int LANES = 2,
  parameter  int NREG  = 32,
  parameter  int REGW  = 5,
  parameter  int LAT_W = 3,
  parameter  int CNT_W = 32,
  localparam int LIW   = laneIdxW(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES-1:0]       dec_valid,
  input  logic [LANES*REGW-1:0]  dec_rs1,
  input  logic [LANES*REGW-1:0]  dec_rs2,
  input  logic [LANES*REGW-1:0]  dec_rd,
  input  logic [LANES-1:0]       dec_wr,
  input  logic [LANES-1:0]       dec_ctrl,
  input  logic [LANES*LAT_W-1:0] dec_lat,
  input  logic                   redirect_valid,
  input  logic [LIW-1:0]         redirect_lane,
  output logic [LANES-1:0]       issue_mask,
  output logic [LANES-1:0]       ex_valid,
  output logic                   stall_fetch,
  output logic                   stall_decode,
  output logic                   flush_decode,
  output logic [LANES-1:0]       flush_ex_mask,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       split_cnt
);

  issueState_e      state, stateNext;
  logic [LANES-1:0] doneMask, doneMaskNext;
  logic [LANES-1:0] pending, blocked, prefix, issue, ldEn, flushEx;
  logic [NREG-1:0]  busy;
  logic             stall, flushDec, inOrder, pj;
  logic [REGW-1:0]  rs1 [LANES];
  logic [REGW-1:0]  rs2 [LANES];
  logic [REGW-1:0]  rd  [LANES];
  logic [LAT_W-1:0] lat [LANES];

  // Unpack per-lane decode fields and form scoreboard load requests.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      rs1[l]  = REGW'(laneField(BUS_MAX'(dec_rs1), l, REGW));
      rs2[l]  = REGW'(laneField(BUS_MAX'(dec_rs2), l, REGW));
      rd[l]   = REGW'(laneField(BUS_MAX'(dec_rd), l, REGW));
      lat[l]  = LAT_W'(laneField(BUS_MAX'(dec_lat), l, LAT_W));
      ldEn[l] = issue[l] & dec_wr[l] & (rd[l] != '0) & (lat[l] != '0);
    end
  end

  // Hazards against in-flight results and against older pending lanes of this bundle.
  always_comb begin
    pj = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      pending[i] = dec_valid[i] & ~doneMask[i];
      blocked[i] = ((rs1[i] != '0) & busy[rs1[i]]) | ((rs2[i] != '0) & busy[rs2[i]]);
      for (int j = 0; j < i; j++) begin
        pj = dec_valid[j] & ~doneMask[j];
        blocked[i] = blocked[i]
                   | (pj & dec_wr[j] & (((rs1[i] != '0) & (rs1[i] == rd[j])) |
                                        ((rs2[i] != '0) & (rs2[i] == rd[j])) |
                                        (rd[i] == rd[j])))
                   | (pj & dec_ctrl[i] & dec_ctrl[j]);
      end
    end
  end

  // Issue selection and bundle sequencing; redirect overrides everything.
  always_comb begin
    issue        = '0;
    flushEx      = '0;
    flushDec     = 1'b0;
    stall        = 1'b0;
    stateNext    = RUN;
    doneMaskNext = '0;
    inOrder      = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      inOrder   = inOrder & ~(pending[i] & blocked[i]);
      prefix[i] = pending[i] & inOrder;
    end
    if (!rst_n) begin
      issue = '0;
    end else if (redirect_valid) begin
      flushDec = 1'b1;
      for (int i = 0; i < LANES; i++) begin
        flushEx[i] = (LIW'(i) > redirect_lane);
      end
    end else if ((pending & ~prefix) == '0) begin
      issue = prefix;
    end else begin
      issue        = prefix;
      stall        = 1'b1;
      stateNext    = PART;
      doneMaskNext = doneMask | prefix;
    end
  end

  assign issue_mask    = issue;
  assign ex_valid      = issue;
  assign stall_fetch   = stall;
  assign stall_decode  = stall;
  assign flush_decode  = flushDec;
  assign flush_ex_mask = flushEx;

  // Bundle state, completion mask and saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      doneMask  <= '0;
      stall_cnt <= '0;
      split_cnt <= '0;
    end else begin
      state    <= stateNext;
      doneMask <= doneMaskNext;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if ((state == RUN) && (stateNext == PART) && (split_cnt != '1)) begin
        split_cnt <= split_cnt + CNT_W'(1);
      end
    end
  end

  reg_scoreboard #(
    .LANES (LANES),
    .NREG  (NREG),
    .REGW  (REGW),
    .LAT_W (LAT_W)
  ) uScoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .ldEn     (ldEn),
    .ldReg    (dec_rd),
    .ldLat    (dec_lat),
    .relValid (redirect_valid),
    .relLane  (redirect_lane),
    .busy     (busy)
  );

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a 2-lane instance for the main scenarios and a
// 4-lane instance with a 4-bit counter for wide-bundle splitting and saturation.
module tb_issue_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;
  int   checks   = 0;
  int   failures = 0;

  logic [1:0]  aValid, aWr, aCtrl, aMask, aEx, aFlushEx;
  logic [9:0]  aRs1, aRs2, aRd;
  logic [5:0]  aLat;
  logic        aRedir, aStallF, aStallD, aFlushD;
  logic [0:0]  aRedirLane;
  logic [31:0] aStallCnt, aSplitCnt;

  logic [3:0]  bValid, bWr, bCtrl, bMask, bEx, bFlushEx;
  logic [19:0] bRs1, bRs2, bRd;
  logic [11:0] bLat;
  logic        bRedir, bStallF, bStallD, bFlushD;
  logic [1:0]  bRedirLane;
  logic [3:0]  bStallCnt, bSplitCnt;

  issue_scoreboard #(.LANES(2), .NREG(32), .REGW(5), .LAT_W(3), .CNT_W(32)) uDutA (
    .clk(clk), .rst_n(rstN), .dec_valid(aValid), .dec_rs1(aRs1), .dec_rs2(aRs2),
    .dec_rd(aRd), .dec_wr(aWr), .dec_ctrl(aCtrl), .dec_lat(aLat),
    .redirect_valid(aRedir), .redirect_lane(aRedirLane), .issue_mask(aMask),
    .ex_valid(aEx), .stall_fetch(aStallF), .stall_decode(aStallD),
    .flush_decode(aFlushD), .flush_ex_mask(aFlushEx), .stall_cnt(aStallCnt),
    .split_cnt(aSplitCnt)
  );

  issue_scoreboard #(.LANES(4), .NREG(32), .REGW(5), .LAT_W(3), .CNT_W(4)) uDutB (
    .clk(clk), .rst_n(rstN), .dec_valid(bValid), .dec_rs1(bRs1), .dec_rs2(bRs2),
    .dec_rd(bRd), .dec_wr(bWr), .dec_ctrl(bCtrl), .dec_lat(bLat),
    .redirect_valid(bRedir), .redirect_lane(bRedirLane), .issue_mask(bMask),
    .ex_valid(bEx), .stall_fetch(bStallF), .stall_decode(bStallD),
    .flush_decode(bFlushD), .flush_ex_mask(bFlushEx), .stall_cnt(bStallCnt),
    .split_cnt(bSplitCnt)
  );

  // Redirect lane must name an existing lane.
  always @(posedge clk) begin
    if (rstN && aRedir) assert (int'(aRedirLane) < 2) else $error("redirect lane out of range A");
    if (rstN && bRedir) assert (int'(bRedirLane) < 4) else $error("redirect lane out of range B");
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearA();
    aValid = '0; aWr = '0; aCtrl = '0; aRs1 = '0; aRs2 = '0; aRd = '0; aLat = '0;
  endtask

  task automatic clearB();
    bValid = '0; bWr = '0; bCtrl = '0; bRs1 = '0; bRs2 = '0; bRd = '0; bLat = '0;
  endtask

  task automatic setA(input int l, input int v, input int rs1, input int rs2, input int rd,
                      input int wr, input int ctrl, input int lat);
    aValid[l] = 1'(v); aWr[l] = 1'(wr); aCtrl[l] = 1'(ctrl);
    aRs1[l*5 +: 5] = 5'(rs1); aRs2[l*5 +: 5] = 5'(rs2); aRd[l*5 +: 5] = 5'(rd);
    aLat[l*3 +: 3] = 3'(lat);
  endtask

  task automatic setB(input int l, input int v, input int rs1, input int rs2, input int rd,
                      input int wr, input int ctrl, input int lat);
    bValid[l] = 1'(v); bWr[l] = 1'(wr); bCtrl[l] = 1'(ctrl);
    bRs1[l*5 +: 5] = 5'(rs1); bRs2[l*5 +: 5] = 5'(rs2); bRd[l*5 +: 5] = 5'(rd);
    bLat[l*3 +: 3] = 3'(lat);
  endtask

  initial begin
    rstN = 1'b0; aRedir = 1'b0; aRedirLane = '0; bRedir = 1'b0; bRedirLane = '0;
    clearA(); clearB();
    // add x5 / sub x6,x5 presented while still in reset
    setA(0, 1, 1, 2, 5, 1, 0, 0);
    setA(1, 1, 5, 0, 6, 1, 0, 0);
    tick(); #1;
    checkEq("rst_issue", 32'(aMask), 32'd0);
    checkEq("rst_stall", 32'(aStallD), 32'd0);
    checkEq("rst_stallcnt", aStallCnt, 32'd0);

    // Intra-bundle RAW splits the bundle
    rstN = 1'b1; #1;
    checkEq("t1_c0_issue", 32'(aMask), 32'b01);
    checkEq("t1_c0_ex", 32'(aEx), 32'b01);
    checkEq("t1_c0_stall", 32'(aStallD), 32'd1);
    checkEq("t1_c0_stallf", 32'(aStallF), 32'd1);
    tick(); #1;
    checkEq("t1_c1_issue", 32'(aMask), 32'b10);
    checkEq("t1_c1_stall", 32'(aStallD), 32'd0);
    checkEq("t1_c1_split", aSplitCnt, 32'd1);
    checkEq("t1_c1_stallcnt", aStallCnt, 32'd1);
    tick();

    // Load-use: lw x7 lat1 then a reader of x7
    clearA(); setA(0, 1, 2, 0, 7, 1, 0, 1); #1;
    checkEq("t2_lw_issue", 32'(aMask), 32'b01);
    tick();
    clearA(); setA(0, 1, 7, 0, 8, 1, 0, 0); setA(1, 1, 1, 0, 10, 1, 0, 0); #1;
    checkEq("t2_use_issue", 32'(aMask), 32'b00);
    checkEq("t2_use_stall", 32'(aStallD), 32'd1);
    tick(); #1;
    checkEq("t2_after_issue", 32'(aMask), 32'b11);
    checkEq("t2_stallcnt", aStallCnt, 32'd2);
    checkEq("t2_split", aSplitCnt, 32'd2);
    tick();

    // Two branches: one control instruction per cycle
    clearA(); setA(0, 1, 1, 2, 0, 0, 1, 0); setA(1, 1, 3, 4, 0, 0, 1, 0); #1;
    checkEq("t3_c0_issue", 32'(aMask), 32'b01);
    tick(); #1;
    checkEq("t3_c1_issue", 32'(aMask), 32'b10);
    checkEq("t3_split", aSplitCnt, 32'd3);
    tick();

    // Branch + lw x9 lat2, then redirect from lane0 releases x9
    clearA(); setA(0, 1, 1, 0, 0, 0, 1, 0); setA(1, 1, 2, 0, 9, 1, 0, 2); #1;
    checkEq("t4_issue", 32'(aMask), 32'b11);
    tick();
    clearA(); setA(0, 1, 9, 0, 11, 1, 0, 0);
    aRedir = 1'b1; aRedirLane = 1'b0; #1;
    checkEq("t4_redir_issue", 32'(aMask), 32'b00);
    checkEq("t4_redir_flushd", 32'(aFlushD), 32'd1);
    checkEq("t4_redir_flushex", 32'(aFlushEx), 32'b10);
    checkEq("t4_redir_stall", 32'(aStallD), 32'd0);
    tick();
    aRedir = 1'b0; #1;
    checkEq("t4_post_issue", 32'(aMask), 32'b01);
    checkEq("t4_post_stall", 32'(aStallD), 32'd0);
    checkEq("t4_post_flushd", 32'(aFlushD), 32'd0);
    checkEq("t4_post_flushex", 32'(aFlushEx), 32'b00);
    checkEq("t4_stallcnt", aStallCnt, 32'd3);
    tick();

    // Reset while in PART with x3 in flight
    clearA(); setA(0, 1, 1, 0, 3, 1, 0, 3); setA(1, 1, 3, 0, 12, 1, 0, 0); #1;
    checkEq("t5_pre_issue", 32'(aMask), 32'b01);
    tick();
    rstN = 1'b0; #1;
    checkEq("t5_rst_issue", 32'(aMask), 32'b00);
    checkEq("t5_rst_stall", 32'(aStallD), 32'd0);
    checkEq("t5_rst_stallf", 32'(aStallF), 32'd0);
    tick();
    rstN = 1'b1; #1;
    checkEq("t5_stallcnt", aStallCnt, 32'd0);
    checkEq("t5_split", aSplitCnt, 32'd0);
    checkEq("t5_issue", 32'(aMask), 32'b01);
    tick();
    clearA();

    // 4 lanes: lane2 depends on lane1
    setB(0, 1, 0, 0, 1, 1, 0, 0); setB(1, 1, 0, 0, 2, 1, 0, 0);
    setB(2, 1, 2, 0, 3, 1, 0, 0); setB(3, 1, 0, 0, 4, 1, 0, 0); #1;
    checkEq("t6_c0_issue", 32'(bMask), 32'b0011);
    checkEq("t6_c0_stall", 32'(bStallD), 32'd1);
    tick(); #1;
    checkEq("t6_c1_issue", 32'(bMask), 32'b1100);
    checkEq("t6_c1_split", 32'(bSplitCnt), 32'd1);
    checkEq("t6_c1_stallcnt", 32'(bStallCnt), 32'd1);
    tick();

    // Self-dependent lat7 writer: 7 stall cycles per 8 until the 4-bit counter saturates
    clearB(); setB(0, 1, 5, 0, 5, 1, 0, 7); #1;
    checkEq("t6_sat_c0_issue", 32'(bMask), 32'b0001);
    for (int k = 0; k < 8; k++) tick();
    checkEq("t6_sat_c8_issue", 32'(bMask), 32'b0001);
    checkEq("t6_sat_c8_stallcnt", 32'(bStallCnt), 32'd8);
    checkEq("t6_sat_c8_split", 32'(bSplitCnt), 32'd2);
    for (int k = 0; k < 16; k++) tick();
    checkEq("t6_sat_stallcnt", 32'(bStallCnt), 32'd15);
    checkEq("t6_sat_split", 32'(bSplitCnt), 32'd4);

    // Flush mask covers only lanes younger than the redirecting lane
    bRedir = 1'b1; bRedirLane = 2'd1; #1;
    checkEq("t6_redir1_flushex", 32'(bFlushEx), 32'b1100);
    checkEq("t6_redir1_issue", 32'(bMask), 32'b0000);
    bRedirLane = 2'd2; #1;
    checkEq("t6_redir2_flushex", 32'(bFlushEx), 32'b1000);
    checkEq("t6_redir2_flushd", 32'(bFlushD), 32'd1);
    tick();
    bRedir = 1'b0; clearB(); #1;
    checkEq("t6_idle_flushex", 32'(bFlushEx), 32'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
